modulation_az: RTL and testbench

Auto-zero modulation sequencer for the DMM front end. It alternates the azmux (U414) between the signal input and the LO/zero reference, drives the pre-charge switch, and emits a one-cycle sample strobe at the end of every integration phase. Its 18-bit output has the same layout as the conditioning vector and feeds one data input of the 4-to-1 mode mux. With this block selected, the front end runs autonomously instead of from the direct register.

---
 rtl/modulation_az_pkg.sv | 31 +++
 rtl/modulation_az_phase_timer.sv | 29 ++
 rtl/modulation_az.sv | 119 +++++++++++
 tb/tb_modulation_az.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/modulation_az_pkg.sv
// Shared definitions for the auto-zero modulation sequencer:
// state codes, conditioning vector layout and the phase order.
package modulation_az_pkg;

  localparam int COND_BITS = 18;

  localparam int AZMUX_LSB = 0;
  localparam int HIMUX_LSB = 4;
  localparam int PC_SW     = 8;
  localparam int LED       = 9;
  localparam int MON_LSB   = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SIG_SETTLE = 3'd1,
    SIG_INTEG  = 3'd2,
    LO_SETTLE  = 3'd3,
    LO_INTEG   = 3'd4
  } az_state_t;

  function automatic az_state_t az_next(input az_state_t s);
    case (s)
      SIG_SETTLE: return SIG_INTEG;
      SIG_INTEG:  return LO_SETTLE;
      LO_SETTLE:  return LO_INTEG;
      LO_INTEG:   return SIG_SETTLE;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/modulation_az_phase_timer.sv
// Loadable down-counter timing one sequencer phase.
// done flags zero; last flags the clock before zero.
module modulation_az_phase_timer #(
  parameter int CNT_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [CNT_BITS-1:0] value,
  output logic                done,
  output logic                last
);

  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_BITS'(1);
    end
  end

  assign done = (count == '0);
  assign last = (count == CNT_BITS'(1));

endmodule

// File: rtl/modulation_az.sv
// Auto-zero sequencer: alternates azmux between signal and LO,
// drives the pre-charge switch and strobes sample per integration.
module modulation_az
  import modulation_az_pkg::*;
#(
  parameter int NUM_BITS = COND_BITS,
  parameter int CNT_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [3:0]          himux,
  input  logic [3:0]          azmux_sig,
  input  logic [3:0]          azmux_lo,
  input  logic [CNT_BITS-1:0] clk_count_settle,
  input  logic [CNT_BITS-1:0] clk_count_integ,
  output logic [NUM_BITS-1:0] out,
  output logic                sample,
  output logic                sample_phase
);

  az_state_t           st, nxt;
  logic [3:0]          lat_sig, lat_lo;
  logic [CNT_BITS-1:0] lat_settle, lat_integ;
  logic [3:0]          azmux_q, himux_q;
  logic                pc_q, led_q, sample_q, phase_q;

  logic                load, done, last, enter_sig;
  logic                sample_d;
  logic [3:0]          azmux_d;
  logic [CNT_BITS-1:0] dur_src, load_val;

  modulation_az_phase_timer #(.CNT_BITS(CNT_BITS)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .value   (load_val),
    .done    (done),
    .last    (last)
  );

  always_comb begin
    nxt = st;
    if (!enable)
      nxt = IDLE;
    else if (st == IDLE)
      nxt = SIG_SETTLE;
    else if (done)
      nxt = az_next(st);

    load      = (nxt != st);
    enter_sig = load && (nxt == SIG_SETTLE);

    // SIG_SETTLE entry uses live inputs: they are latched on this same edge
    case (nxt)
      SIG_SETTLE:          dur_src = clk_count_settle;
      SIG_INTEG, LO_INTEG: dur_src = lat_integ;
      LO_SETTLE:           dur_src = lat_settle;
      default:             dur_src = '0;
    endcase
    load_val = (dur_src == '0) ? '0 : dur_src - CNT_BITS'(1);

    sample_d = (nxt == SIG_INTEG || nxt == LO_INTEG) &&
               (load ? (load_val == '0) : last);

    azmux_d = '0;
    if (enter_sig)
      azmux_d = azmux_sig;
    else if (nxt == SIG_SETTLE || nxt == SIG_INTEG)
      azmux_d = lat_sig;
    else if (nxt == LO_SETTLE || nxt == LO_INTEG)
      azmux_d = lat_lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      lat_sig    <= '0;
      lat_lo     <= '0;
      lat_settle <= '0;
      lat_integ  <= '0;
      azmux_q    <= '0;
      himux_q    <= '0;
      pc_q       <= 1'b0;
      led_q      <= 1'b0;
      sample_q   <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      st       <= nxt;
      himux_q  <= himux;
      azmux_q  <= azmux_d;
      pc_q     <= (nxt == SIG_SETTLE || nxt == SIG_INTEG);
      sample_q <= sample_d;
      phase_q  <= sample_d && (nxt == SIG_INTEG);
      if (enter_sig) begin
        lat_sig    <= azmux_sig;
        lat_lo     <= azmux_lo;
        lat_settle <= clk_count_settle;
        lat_integ  <= clk_count_integ;
        led_q      <= (st == IDLE) ? 1'b1 : ~led_q;
      end else if (nxt == IDLE) begin
        led_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out                 = '0;
    out[AZMUX_LSB +: 4] = azmux_q;
    out[HIMUX_LSB +: 4] = himux_q;
    out[PC_SW]          = pc_q;
    out[LED]            = led_q;
    out[MON_LSB +: 8]   = {2'b00, st, phase_q, sample_q, pc_q};
  end

  assign sample       = sample_q;
  assign sample_phase = phase_q;

endmodule

// File: tb/tb_modulation_az.sv
// Bench for modulation_az: table vectors, corner sequences and
// randomized runs against a position-in-cycle reference model.
module tb_modulation_az;

  localparam int CB = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic [3:0]    himux = '0;
  logic [3:0]    azmux_sig = '0;
  logic [3:0]    azmux_lo = '0;
  logic [CB-1:0] settle = '0;
  logic [CB-1:0] integ = '0;
  logic [17:0]   out;
  logic          sample;
  logic          sample_phase;

  always #25 clk = ~clk;

  modulation_az #(.NUM_BITS(18), .CNT_BITS(CB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .himux            (himux),
    .azmux_sig        (azmux_sig),
    .azmux_lo         (azmux_lo),
    .clk_count_settle (settle),
    .clk_count_integ  (integ),
    .out              (out),
    .sample           (sample),
    .sample_phase     (sample_phase)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: position t inside the current full cycle
  bit         m_run;
  int         m_t, m_ns, m_ni;
  logic [3:0] m_sig, m_lo, m_him;
  bit         m_led, m_sample, m_phase;
  logic [17:0] m_out;

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_ns = 1; m_ni = 1;
    m_sig = '0; m_lo = '0; m_him = '0;
    m_led = 0; m_sample = 0; m_phase = 0; m_out = '0;
  endfunction

  function automatic void model_step(input bit en, input logic [3:0] hm,
      input logic [3:0] sg, input logic [3:0] lo, input int s, input int i);
    int a, b, c;
    logic [2:0] code;
    logic [3:0] az;
    bit pc;
    m_him = hm;
    if (!en) begin
      m_run = 0;
      m_led = 0;
    end else if (!m_run || m_t == 2 * (m_ns + m_ni) - 1) begin
      m_led = m_run ? !m_led : 1'b1;
      m_run = 1;
      m_t = 0;
      m_ns = (s == 0) ? 1 : s;
      m_ni = (i == 0) ? 1 : i;
      m_sig = sg;
      m_lo = lo;
    end else begin
      m_t++;
    end
    if (!m_run) begin
      code = 3'd0; az = '0; pc = 0; m_sample = 0; m_phase = 0;
    end else begin
      a = m_ns;
      b = m_ns + m_ni;
      c = 2 * m_ns + m_ni;
      code = (m_t < a) ? 3'd1 : (m_t < b) ? 3'd2 : (m_t < c) ? 3'd3 : 3'd4;
      pc = (code <= 3'd2);
      az = pc ? m_sig : m_lo;
      m_phase = (m_t == b - 1);
      m_sample = m_phase || (m_t == 2 * b - 1);
    end
    m_out = {2'b00, code, m_phase, m_sample, pc, m_led, pc, m_him, az};
  endfunction

  task automatic tick();
    bit en;
    logic [3:0] hm, sg, lo;
    int s, i;
    en = enable; hm = himux; sg = azmux_sig; lo = azmux_lo;
    s = int'(settle); i = int'(integ);
    @(posedge clk);
    #1;
    model_step(en, hm, sg, lo, s, i);
    check("model", 32'({out, sample, sample_phase}),
          32'({m_out, m_sample, m_phase}));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", 32'({out, sample, sample_phase}), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] st;
    logic [3:0] az;
    bit pc;
    bit smp;
    bit ph;
  } row_t;

  row_t tbl[16];
  int sp[$];
  int exp_sp[4];

  initial begin
    tbl[0]  = '{3'd1, 4'b1110, 1, 0, 0};
    tbl[1]  = '{3'd1, 4'b1110, 1, 0, 0};
    tbl[2]  = '{3'd1, 4'b1110, 1, 0, 0};
    tbl[3]  = '{3'd2, 4'b1110, 1, 0, 0};
    tbl[4]  = '{3'd2, 4'b1110, 1, 0, 0};
    tbl[5]  = '{3'd2, 4'b1110, 1, 0, 0};
    tbl[6]  = '{3'd2, 4'b1110, 1, 0, 0};
    tbl[7]  = '{3'd2, 4'b1110, 1, 1, 1};
    tbl[8]  = '{3'd3, 4'b1011, 0, 0, 0};
    tbl[9]  = '{3'd3, 4'b1011, 0, 0, 0};
    tbl[10] = '{3'd3, 4'b1011, 0, 0, 0};
    tbl[11] = '{3'd4, 4'b1011, 0, 0, 0};
    tbl[12] = '{3'd4, 4'b1011, 0, 0, 0};
    tbl[13] = '{3'd4, 4'b1011, 0, 0, 0};
    tbl[14] = '{3'd4, 4'b1011, 0, 0, 0};
    tbl[15] = '{3'd4, 4'b1011, 0, 1, 0};
    exp_sp = '{8, 16, 29, 42};

    model_reset();
    #5;
    do_reset();

    // Idle with enable low: only himux passes through
    for (int k = 0; k < 1000; k++) begin
      himux = 4'($urandom);
      tick();
      check("idle_no_sample", 32'(sample), 32'd0);
    end

    // Nominal 3/5 sequence against hand-written vectors
    himux = 4'b0101;
    azmux_sig = 4'b1110;
    azmux_lo = 4'b1011;
    settle = 3;
    integ = 5;
    enable = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      row_t r;
      tick();
      r = tbl[(k - 1) % 16];
      check("table", 32'({out[15:13], out[3:0], out[8], out[9],
                           sample, sample_phase}),
            32'({r.st, r.az, r.pc, (k <= 16) ? 1'b1 : 1'b0,
                 r.smp, r.ph}));
    end

    // Integ change mid-SIG_INTEG only applies to the next cycle
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 5) integ = 10;
      if (sample) sp.push_back(k);
    end
    check("integ_chg_count", 32'(sp.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("integ_chg_pos", 32'((i < sp.size()) ? sp[i] : -1),
            32'(exp_sp[i]));

    // Drop enable in LO_INTEG with count 2, then re-enable
    integ = 5;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 1; k <= 14; k++) tick();
    check("lo_integ_state", 32'(out[15:13]), 32'd4);
    enable = 1'b0;
    tick();
    check("drop_idle", 32'({out, sample}),
          32'({10'b0, himux, 4'b0000, 1'b0}));
    tick();
    check("drop_no_sample", 32'(sample), 32'd0);
    enable = 1'b1;
    tick();
    check("reenable", 32'({out[15:13], out[9], out[8], out[3:0]}),
          32'({3'd1, 1'b1, 1'b1, 4'b1110}));

    // Async reset in mid-SIG_INTEG, restart with enable held high
    for (int k = 2; k <= 5; k++) tick();
    check("sig_integ_state", 32'(out[15:13]), 32'd2);
    do_reset();
    for (int k = 0; k < 40; k++) tick();

    // Zero durations: one clock per state
    enable = 1'b0;
    tick();
    settle = 0;
    integ = 0;
    enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("zero_dur", 32'({sample, sample_phase}),
            32'({(k % 2 == 0) ? 1'b1 : 1'b0, (k % 4 == 2) ? 1'b1 : 1'b0}));
    end

    // Randomized configurations, enable toggles and resets
    for (int k = 0; k < 3000; k++) begin
      himux = 4'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        settle = CB'($urandom_range(0, 6));
        integ = CB'($urandom_range(0, 6));
        azmux_sig = 4'($urandom);
        azmux_lo = 4'($urandom);
      end
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
